// File: rtl/pic10_pkg.sv
// pic10_pkg: shared PIC10 constants and the W-register operation type.
package pic10_pkg;
    localparam int PIC10_WIDTH = 8;
    typedef enum logic [2:0] {W_NOP, W_LOAD, W_PUSH, W_POP, W_SWAP} w_op_t;
endpackage

// File: rtl/pic10_ctx_lifo.sv
// pic10_ctx_lifo: shadow-copy LIFO with occupancy counter and top-of-stack read port.
// The caller only issues push when not full and pop/swap when not empty.
module pic10_ctx_lifo
    import pic10_pkg::*;
#(
    parameter int WIDTH = PIC10_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       swap,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SPW-1:0]   r_sp;
    logic [AW-1:0]    w_rd;
    logic [AW-1:0]    w_wa;

    // Swap overwrites the current top in place; push writes the slot above it.
    always_comb begin
        w_rd = AW'(r_sp - 1'b1);
        w_wa = swap ? w_rd : AW'(r_sp);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (push | swap) r_mem[w_wa] <= wdata;
            if (push) r_sp <= r_sp + 1'b1;
            else if (pop) r_sp <= r_sp - 1'b1;
        end
    end

    assign top   = r_mem[w_rd];
    assign sp    = r_sp;
    assign full  = (r_sp == SPW'(DEPTH));
    assign empty = (r_sp == '0);
endmodule

// File: rtl/pic10_w_ctx_reg.sv
// pic10_w_ctx_reg: PIC10 W register with a shadow LIFO for interrupt context save/restore.
// Optional PIC10_W_ZFLAG_EN adds a registered W==0 flag; otherwise z_flag is tied low.
module pic10_w_ctx_reg
    import pic10_pkg::*;
#(
    parameter int WIDTH = PIC10_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           alu_bus,
    input  logic                       load_w_reg,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           w_reg_bus,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err,
    output logic                       unf_err,
    output logic                       z_flag
);
    w_op_t            w_op;
    logic [WIDTH-1:0] r_w;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_top;
    logic             w_full;
    logic             w_empty;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             r_ovf;
    logic             r_unf;

    // A full push degrades to a plain load (or nop); pop-side requests on empty do nothing.
    always_comb begin
        w_op = (push & pop) ? (w_empty ? W_NOP : W_SWAP) :
               pop ? (w_empty ? W_NOP : W_POP) :
               (push & ~w_full) ? W_PUSH :
               load_w_reg ? W_LOAD : W_NOP;
        w_next = (w_op == W_SWAP || w_op == W_POP) ? w_top :
                 (w_op == W_LOAD || (w_op == W_PUSH && load_w_reg)) ? alu_bus : r_w;
        w_ovf_set = push & ~pop & w_full;
        w_unf_set = pop & w_empty;
    end

    pic10_ctx_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_op == W_PUSH),
        .pop   (w_op == W_POP),
        .swap  (w_op == W_SWAP),
        .wdata (r_w),
        .top   (w_top),
        .sp    (sp),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_w   <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_w   <= w_next;
            r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
            r_unf <= w_unf_set | (r_unf & ~err_clr);
        end
    end

`ifdef PIC10_W_ZFLAG_EN
    logic r_z;
    always_ff @(posedge clk) begin
        if (reset) r_z <= 1'b1;
        else r_z <= (w_next == '0);
    end
    assign z_flag = r_z;
`else
    assign z_flag = 1'b0;
`endif

    assign w_reg_bus = r_w;
    assign full      = w_full;
    assign empty     = w_empty;
    assign ovf_err   = r_ovf;
    assign unf_err   = r_unf;
endmodule

// File: doc/pic10_w_ctx_reg.md
# pic10_w_ctx_reg

Parametrised successor to the PIC10 W register: a WIDTH-bit working register (first ALU operand) backed by a DEPTH-entry LIFO of shadow copies. The LIFO saves and restores W across interrupt entry and exit without spending data-memory cycles. Sits between the ALU result bus and the ALU A-operand input; driven by the instruction decoder and the interrupt controller.

## Interface
Parameters:
- WIDTH, 8, data width of W and of each shadow entry
- DEPTH, 4, number of shadow entries (≥1)

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_bus  in  WIDTH  value loaded into W
- load_w_reg  in  1  load alu_bus into W
- push  in  1  save current W to LIFO top
- pop  in  1  restore W from LIFO top
- err_clr  in  1  clear sticky error flags
- w_reg_bus  out  WIDTH  current W value (ALU first operand)
- sp  out  $clog2(DEPTH+1)  number of occupied shadow entries
- full  out  1  sp == DEPTH
- empty  out  1  sp == 0
- ovf_err  out  1  sticky: push attempted while full
- unf_err  out  1  sticky: pop attempted while empty
- z_flag  out  1  W == 0 (see Configuration)

## Operation
- Decoded op per cycle (priority top-down):
  - reset: W=0, sp=0, all shadow entries 0, ovf_err=0, unf_err=0, z_flag=1 (0 if macro absent).
  - push&pop, not empty = SWAP: W<=top, top<=old W, sp unchanged; load ignored.
  - push&pop, empty: no change to W/sp; unf_err<=1; load ignored.
  - pop, not empty: W<=top, sp<=sp-1; load ignored.
  - pop, empty: W unchanged, sp unchanged, unf_err<=1; load ignored.
  - push, not full: entry[sp]<=old W (pre-load value), sp<=sp+1; if load_w_reg, W<=alu_bus in same cycle.
  - push, full: stack unchanged, ovf_err<=1; load still applies.
  - load only: W<=alu_bus.
  - none: hold.
- err_clr clears both error flags; a new error in the same cycle wins (flag stays 1).
- Shadow entries above sp are don't-care after pop; never visible on outputs.
- full/empty combinational from registered sp.

## Timing
- All state registered; w_reg_bus, sp, errors and z_flag change only on the rising edge sampling the request.
- Load, push and pop latency: 1 cycle (new value visible after the sampling edge).
- Back-to-back push/pop every cycle supported; no stall or busy signal.
- Reset mid-sequence discards all LIFO contents and pending ops on that edge.
- Push at sp==DEPTH-1 sets full after the edge; a further push is the overflow case.

## Configuration
- PIC10_W_ZFLAG_EN defined: z_flag is a register updated with W, equal to (next W == 0); reset value 1.
- Undefined: z_flag tied to 0, no flag register synthesised; port retained for pin compatibility.

## Structure
- Shared package pic10_pkg: default PIC10_WIDTH=8 constant; typedef enum w_op_t {W_NOP, W_LOAD, W_PUSH, W_POP, W_SWAP} used by the decoder and this block.
- One sub-module: pic10_ctx_lifo (storage array, sp counter, full/empty, top read port); pic10_w_ctx_reg holds W, op decode, error and zero flags.

## Test plan
- Reset t=5..15 with load_w_reg=1, alu_bus=8'h33 -> w_reg_bus=00h, sp=0, empty=1, z_flag=1 (macro on).
- Load 55h, push, load AAh, pop -> W reads 55h, AAh, 55h; sp 0→1→0.
- Same-cycle push+load alu_bus=8'hC3 with W=55h -> entry0=55h, W=C3h; pop -> W=55h.
- Push DEPTH+1 times (DEPTH=4) -> full=1 after 4th push, ovf_err=1 after 5th, sp=4; err_clr -> ovf_err=0.
- Pop while empty with load_w_reg=1, alu_bus=8'h11 -> W unchanged, unf_err=1, sp=0.
- W=AAh, top=55h, push+pop -> W=55h, top=AAh, sp unchanged; macro off -> z_flag constant 0 throughout.
